// File: rtl/pattern_stream_monitor.sv
// pattern_stream_monitor
//
// Checks a video pattern stream against an expected frame geometry and
// publishes per-frame results: a running checksum, an optional CRC-32 and
// three error flags. Results are updated together with a one-cycle
// frame_done_o pulse and held until the next frame completes.
//
// Optional feature macro: PATTERN_MONITOR_CRC_EN
//   defined   -> crc_o is the CRC-32 of the last frame (poly 0x04C11DB7,
//                init 0xFFFFFFFF, beat bytes LSB byte first, each byte
//                MSB bit first, no final XOR)
//   undefined -> no CRC logic, crc_o is tied to 0
//
// Ports
//   clk_i           single clock, rising edge
//   rst_i           synchronous active-high reset
//   enable_i        start / continue monitoring frames
//   valid_i         beat valid from the pattern generator
//   ready_o         high while a frame is being collected
//   data_i          pixel beat
//   end_of_video_i  last beat of a frame
//   width_i         expected pixels per line (latched at frame start)
//   height_i        expected lines per frame (latched at frame start)
//   frame_done_o    one-cycle pulse when results publish
//   err_o           [0] early EOV, [1] missing EOV, [2] zero geometry
//   frame_cnt_o     completed frames, wraps
//   checksum_o      32-bit sum of the last frame's beats
//   crc_o           CRC-32 of the last frame (0 without the macro)
//
// state  | meaning
// IDLE   | waiting for enable_i, ready_o low
// ACTIVE | collecting beats of a frame, ready_o high
// DONE   | one cycle: results published, frame_done_o high

module pattern_stream_monitor #(
    parameter int DATA_WIDTH = 24,
    parameter int FCNT_W     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  end_of_video_i,
    input  logic [31:0]           width_i,
    input  logic [31:0]           height_i,
    output logic                  frame_done_o,
    output logic [2:0]            err_o,
    output logic [FCNT_W-1:0]     frame_cnt_o,
    output logic [31:0]           checksum_o,
    output logic [31:0]           crc_o
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t      state;
    logic [31:0] width_q;
    logic [31:0] height_q;
    logic [31:0] col_q;
    logic [31:0] row_q;
    logic [31:0] sum_q;
    logic        err_missing_q;

    logic        accept;
    logic        geo_zero;
    logic        at_last;
    logic [31:0] sum_next;

    // ready_o is only ever high in ACTIVE, so it alone qualifies a beat
    assign accept   = valid_i & ready_o;
    assign geo_zero = (width_q == 32'd0) || (height_q == 32'd0);
    assign at_last  = (row_q == height_q - 32'd1) && (col_q == width_q - 32'd1);
    assign sum_next = sum_q + 32'(data_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            ready_o       <= 1'b0;
            frame_done_o  <= 1'b0;
            err_o         <= 3'b000;
            frame_cnt_o   <= '0;
            checksum_o    <= 32'd0;
            width_q       <= 32'd0;
            height_q      <= 32'd0;
            col_q         <= 32'd0;
            row_q         <= 32'd0;
            sum_q         <= 32'd0;
            err_missing_q <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        width_q       <= width_i;
                        height_q      <= height_i;
                        col_q         <= 32'd0;
                        row_q         <= 32'd0;
                        sum_q         <= 32'd0;
                        err_missing_q <= 1'b0;
                        ready_o       <= 1'b1;
                        state         <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        sum_q <= sum_next;
                        if (col_q == width_q - 32'd1) begin
                            col_q <= 32'd0;
                            row_q <= row_q + 32'd1;
                        end else begin
                            col_q <= col_q + 32'd1;
                        end
                        if (end_of_video_i) begin
                            state        <= DONE;
                            ready_o      <= 1'b0;
                            frame_done_o <= 1'b1;
                            checksum_o   <= sum_next;
                            frame_cnt_o  <= frame_cnt_o + FCNT_W'(1);
                            // Early EOV only means "stopped before the last
                            // position"; once the last position has been
                            // passed the overrun is reported as missing EOV.
                            err_o <= {geo_zero, err_missing_q,
                                      ~geo_zero & ~err_missing_q & ~at_last};
                        end else if (at_last) begin
                            err_missing_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (enable_i) begin
                        width_q       <= width_i;
                        height_q      <= height_i;
                        col_q         <= 32'd0;
                        row_q         <= 32'd0;
                        sum_q         <= 32'd0;
                        err_missing_q <= 1'b0;
                        ready_o       <= 1'b1;
                        state         <= ACTIVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef PATTERN_MONITOR_CRC_EN
    localparam int          NBYTES   = DATA_WIDTH / 8;
    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic        frame_start;

    // Bytes go in LSB byte first; within a byte the MSB is shifted in first.
    function automatic logic [31:0] crc_beat(input logic [31:0] crc,
                                             input logic [DATA_WIDTH-1:0] d);
        logic [31:0] c;
        logic [7:0]  b;
        c = crc;
        for (int i = 0; i < NBYTES; i++) begin
            b = d[8*i +: 8];
            for (int j = 7; j >= 0; j--) begin
                if (c[31] ^ b[j]) begin
                    c = {c[30:0], 1'b0} ^ CRC_POLY;
                end else begin
                    c = {c[30:0], 1'b0};
                end
            end
        end
        return c;
    endfunction

    assign crc_next    = crc_beat(crc_q, data_i);
    assign frame_start = ((state == IDLE) || (state == DONE)) && enable_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
            crc_o <= 32'd0;
        end else if (frame_start) begin
            crc_q <= CRC_INIT;
        end else if (accept) begin
            crc_q <= crc_next;
            if (end_of_video_i) begin
                crc_o <= crc_next;
            end
        end
    end
`else
    assign crc_o = 32'd0;
`endif

endmodule

// File: tb/tb_pattern_stream_monitor.sv
module tb_pattern_stream_monitor;

    localparam int DW = 24;
    localparam int FW = 16;

    typedef logic [31:0] word_q_t[$];

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          end_of_video_i;
    logic [31:0]   width_i;
    logic [31:0]   height_i;
    logic          frame_done_o;
    logic [2:0]    err_o;
    logic [FW-1:0] frame_cnt_o;
    logic [31:0]   checksum_o;
    logic [31:0]   crc_o;

    pattern_stream_monitor #(.DATA_WIDTH(DW), .FCNT_W(FW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .data_i         (data_i),
        .end_of_video_i (end_of_video_i),
        .width_i        (width_i),
        .height_i       (height_i),
        .frame_done_o   (frame_done_o),
        .err_o          (err_o),
        .frame_cnt_o    (frame_cnt_o),
        .checksum_o     (checksum_o),
        .crc_o          (crc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- reference model ----------------
    logic [31:0]   crc_tab [256];
    int            m_phase = 0;      // 0 idle, 1 collecting, 2 results cycle
    logic          m_init  = 1'b0;
    logic [31:0]   m_w;
    logic [31:0]   m_h;
    word_q_t       m_beats;
    logic [2:0]    exp_err;
    logic [FW-1:0] exp_cnt;
    logic [31:0]   exp_sum;
    logic [31:0]   exp_crc;

    function automatic void build_crc_table();
        logic [31:0] c;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i) << 24;
            for (int k = 0; k < 8; k++) begin
                c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
            end
            crc_tab[i] = c;
        end
    endfunction

    function automatic logic [31:0] model_crc(input word_q_t b);
        logic [31:0] c;
        logic [7:0]  byt;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            for (int k = 0; k < DW/8; k++) begin
                byt = b[i][8*k +: 8];
                c = (c << 8) ^ crc_tab[c[31:24] ^ byt];
            end
        end
        return c;
    endfunction

    function automatic void model_finish_frame();
        logic [63:0] total;
        logic [63:0] n;
        logic [31:0] s;
        s = 32'd0;
        foreach (m_beats[i]) s = s + m_beats[i];
        exp_sum = s;
        exp_cnt = exp_cnt + FW'(1);
        total = {32'd0, m_w} * {32'd0, m_h};
        n     = 64'(m_beats.size());
        if (m_w == 32'd0 || m_h == 32'd0) exp_err = 3'b100;
        else if (n < total)                exp_err = 3'b001;
        else if (n > total)                exp_err = 3'b010;
        else                               exp_err = 3'b000;
`ifdef PATTERN_MONITOR_CRC_EN
        exp_crc = model_crc(m_beats);
`else
        exp_crc = 32'd0;
`endif
    endfunction

    // Inputs change just after the rising edge, so the values seen here are
    // the ones the next rising edge will act on.
    always @(negedge clk_i) begin
        if (m_init) begin
            n_vec++;
            if (ready_o !== (m_phase == 1) || frame_done_o !== (m_phase == 2) ||
                err_o !== exp_err || frame_cnt_o !== exp_cnt ||
                checksum_o !== exp_sum || crc_o !== exp_crc) begin
                n_miss++;
                $display("FAIL cycle_check t=%0t got rdy=%b done=%b err=%b cnt=%0d sum=%h crc=%h required rdy=%b done=%b err=%b cnt=%0d sum=%h crc=%h",
                         $time, ready_o, frame_done_o, err_o, frame_cnt_o, checksum_o, crc_o,
                         (m_phase == 1), (m_phase == 2), exp_err, exp_cnt, exp_sum, exp_crc);
            end
        end
        if (rst_i === 1'b1) begin
            m_phase = 0;
            exp_err = 3'b000;
            exp_cnt = '0;
            exp_sum = 32'd0;
            exp_crc = 32'd0;
            m_beats.delete();
            m_init  = 1'b1;
        end else if (m_init) begin
            case (m_phase)
                0: if (enable_i) begin
                    m_w = width_i; m_h = height_i; m_beats.delete(); m_phase = 1;
                end
                1: if (valid_i) begin
                    m_beats.push_back(32'(data_i));
                    if (end_of_video_i) begin
                        model_finish_frame();
                        m_phase = 2;
                    end
                end
                default: if (enable_i) begin
                    m_w = width_i; m_h = height_i; m_beats.delete(); m_phase = 1;
                end else begin
                    m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic start_frame(input logic [31:0] w, input logic [31:0] h, input bit hold);
        enable_i = 1'b1;
        width_i  = w;
        height_i = h;
        tick();
        if (!hold) enable_i = 1'b0;
        width_i  = $urandom;
        height_i = $urandom;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic eov, input int max_gap);
        int waitc;
        valid_i = 1'b0;
        repeat ($urandom_range(max_gap, 0)) begin
            data_i         = DW'($urandom);
            end_of_video_i = 1'($urandom);
            tick();
        end
        valid_i        = 1'b1;
        data_i         = d;
        end_of_video_i = eov;
        waitc = 0;
        while (ready_o !== 1'b1 && waitc <= 50) begin
            tick();
            waitc++;
        end
        if (waitc > 50) begin
            n_vec++;
            n_miss++;
            $display("FAIL ready_timeout: got ready_o=%b required 1 within 50 cycles", ready_o);
        end
        tick();
        valid_i        = 1'b0;
        end_of_video_i = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        word_q_t     pin;
        logic [31:0] w, h, total;
        int          n;

        build_crc_table();
        rst_i = 1'b1; enable_i = 1'b0; valid_i = 1'b0; end_of_video_i = 1'b0;
        data_i = '0; width_i = 32'd0; height_i = 32'd0;
        repeat (2) tick();
        rst_i = 1'b0;

        check("reset_ready",    32'(ready_o),      32'd0);
        check("reset_done",     32'(frame_done_o), 32'd0);
        check("reset_err",      32'(err_o),        32'd0);
        check("reset_cnt",      32'(frame_cnt_o),  32'd0);
        check("reset_checksum", checksum_o,        32'd0);
        check("reset_crc",      crc_o,             32'd0);

        // Pin the CRC model: CRC-32/MPEG-2 of "123456789"
        pin = '{32'h333231, 32'h363534, 32'h393837};
        check("model_crc_pin", model_crc(pin), 32'h0376E6E7);

        // Full 4x2 frame, data 1..8
        start_frame(32'd4, 32'd2, 1'b0);
        for (int i = 1; i <= 8; i++) send_beat(DW'(i), (i == 8), 0);
        check("f1_done_latency", 32'(frame_done_o), 32'd1);
        check("f1_checksum",     checksum_o,        32'd36);
        check("f1_err",          32'(err_o),        32'd0);
        check("f1_cnt",          32'(frame_cnt_o),  32'd1);
        tick();
        check("f1_done_pulse",   32'(frame_done_o), 32'd0);
        check("f1_idle_ready",   32'(ready_o),      32'd0);
        check("f1_hold_sum",     checksum_o,        32'd36);

        // Early EOV on 5th beat
        start_frame(32'd4, 32'd2, 1'b0);
        for (int i = 1; i <= 5; i++) send_beat(DW'(24'h10), (i == 5), 2);
        check("early_err",      32'(err_o),       32'd1);
        check("early_checksum", checksum_o,       32'h50);
        check("early_cnt",      32'(frame_cnt_o), 32'd2);

        // Missing EOV: 2x2 with 6 beats
        start_frame(32'd2, 32'd2, 1'b0);
        for (int i = 1; i <= 6; i++) send_beat(DW'(i), (i == 6), 1);
        check("missing_err", 32'(err_o),       32'd2);
        check("missing_sum", checksum_o,       32'd21);
        check("missing_cnt", 32'(frame_cnt_o), 32'd3);

        // Zero width
        start_frame(32'd0, 32'd2, 1'b0);
        for (int i = 1; i <= 3; i++) send_beat(DW'(i), (i == 3), 1);
        check("zero_geo_err", 32'(err_o),       32'd4);
        check("zero_geo_cnt", 32'(frame_cnt_o), 32'd4);

        // Known CRC frame
        start_frame(32'd3, 32'd1, 1'b0);
        send_beat(24'h333231, 1'b0, 0);
        send_beat(24'h363534, 1'b0, 0);
        send_beat(24'h393837, 1'b1, 0);
`ifdef PATTERN_MONITOR_CRC_EN
        check("crc_check_value", crc_o, 32'h0376E6E7);
`else
        check("crc_tied_zero",   crc_o, 32'd0);
`endif
        check("crc_frame_err", 32'(err_o), 32'd0);

        // Reset in the middle of a frame, then a full frame of 0xFFFFFF
        start_frame(32'd4, 32'd2, 1'b0);
        for (int i = 1; i <= 3; i++) send_beat(DW'(24'h123), 1'b0, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("midrst_cnt",   32'(frame_cnt_o), 32'd0);
        check("midrst_sum",   checksum_o,       32'd0);
        check("midrst_ready", 32'(ready_o),     32'd0);
        start_frame(32'd4, 32'd2, 1'b0);
        for (int i = 1; i <= 8; i++) send_beat(DW'(24'hFFFFFF), (i == 8), 1);
        check("postrst_sum", checksum_o,       32'h07FFFFF8);
        check("postrst_cnt", 32'(frame_cnt_o), 32'd1);
        check("postrst_err", 32'(err_o),       32'd0);

        // Random frames: pairs of back-to-back frames with enable held high
        for (int f = 0; f < 12; f++) begin
            for (int p = 0; p < 2; p++) begin
                w = ($urandom_range(9, 0) == 0) ? 32'd0 : 32'($urandom_range(4, 1));
                h = 32'($urandom_range(3, 1));
                total = w * h;
                if (total == 32'd0) n = $urandom_range(4, 1);
                else case ($urandom_range(3, 0))
                    0:       n = int'(total) + 1;
                    1:       n = (total > 1) ? int'(total) - 1 : int'(total);
                    2:       n = int'(total) + 2;
                    default: n = int'(total);
                endcase
                if (p == 0) begin
                    start_frame(w, h, 1'b1);
                end else begin
                    // still in the results cycle of the first frame
                    width_i  = w;
                    height_i = h;
                    tick();
                    enable_i = 1'b0;
                    width_i  = $urandom;
                    height_i = $urandom;
                end
                for (int i = 1; i <= n; i++) send_beat(DW'($urandom), (i == n), 3);
            end
            repeat ($urandom_range(3, 1)) tick();
        end

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pattern_stream_monitor.md
PATTERN_STREAM_MONITOR -- requirements
Module: pattern_stream_monitor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, pixel beat width in bits (3 symbols x 8 bits).
REQ-002 SHALL have parameter FCNT_W, default 16, width of the frame counter.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable_i  input  1  starts or continues frame monitoring.
REQ-006 SHALL have port valid_i  input  1  beat valid from the pattern generator.
REQ-007 SHALL have port ready_o  output  1  beat accepted when valid_i & ready_o.
REQ-008 SHALL have port data_i  input  DATA_WIDTH  pixel data.
REQ-009 SHALL have port end_of_video_i  input  1  marks the last beat of a frame.
REQ-010 SHALL have ports width_i and height_i  input  32 each  expected pixels per line and lines per frame.
REQ-011 SHALL have port frame_done_o  output  1  one-cycle pulse when frame results publish.
REQ-012 SHALL have port err_o  output  3  [0] early EOV, [1] missing EOV, [2] zero geometry.
REQ-013 SHALL have port frame_cnt_o  output  FCNT_W  number of completed frames.
REQ-014 SHALL have port checksum_o  output  32  sum of data_i zero-extended, modulo 2^32, for the last frame.
REQ-015 SHALL have port crc_o  output  32  CRC-32 of the last frame; see Configuration.

Function
REQ-016 SHALL implement states IDLE, ACTIVE, DONE.
REQ-017 IDLE: ready_o=0; when enable_i=1, SHALL latch width_i/height_i, clear col/row/accumulators, and go to ACTIVE the next cycle.
REQ-018 ACTIVE: ready_o=1; each accepted beat SHALL add data_i to the running sum; col increments; at col==width-1, col->0 and row increments; row wraps modulo 2^32.
REQ-019 Accepted beat with end_of_video_i=1 SHALL go to DONE; err[0] SHALL set if (row,col) != (height-1,width-1) at that beat.
REQ-020 Accepted beat at (height-1,width-1) without end_of_video_i SHALL set sticky err[1]; counting continues until EOV.
REQ-021 Latched width or height equal to 0 SHALL set err[2]; err[0] is then not evaluated; the frame ends only on EOV.
REQ-022 DONE lasts exactly 1 cycle, ready_o=0: frame_done_o=1; checksum_o, crc_o and err_o are updated, including the final beat; frame_cnt_o increments, wrapping at 2^FCNT_W.
REQ-023 From DONE, SHALL return to ACTIVE with fresh latched geometry if enable_i=1, else IDLE.
REQ-024 Latency: frame_done_o asserts on the cycle after the EOV beat is accepted.
REQ-025 enable_i deasserted during ACTIVE SHALL NOT abort; the current frame completes.
REQ-026 valid_i=0 cycles SHALL leave all counters unchanged.
REQ-027 err_o/checksum_o/crc_o SHALL hold between DONE cycles.

Reset
REQ-028 rst_i=1 SHALL force IDLE at the next edge from any state, including mid-frame; partial results are discarded.
REQ-029 Reset values: ready_o=0, frame_done_o=0, err_o=0, frame_cnt_o=0, checksum_o=0, crc_o=0.

Configuration
REQ-030 Macro PATTERN_MONITOR_CRC_EN defined: crc_o SHALL be the CRC-32 of the frame.
REQ-031 CRC-32 parameters: poly 0x04C11DB7, init 0xFFFFFFFF, bytes of each beat LSB byte first, MSB-first bits, no final XOR.
REQ-032 Macro undefined: no CRC logic; crc_o SHALL be constant 0; all other behaviour identical.

Verification
REQ-033 Geometry 4x2, 8 beats data=1..8, EOV on 8th -> frame_done_o one cycle later, checksum_o=36, err_o=0, frame_cnt_o=1.
REQ-034 Geometry 4x2, EOV on 5th beat, data all 0x10 -> err_o=3'b001, checksum_o=0x50.
REQ-035 Geometry 2x2, 6 beats, EOV on 6th -> err_o=3'b010; frame ends at beat 6.
REQ-036 width_i=0, 3 beats with EOV on 3rd -> err_o=3'b100, frame_cnt_o increments.
REQ-037 Geometry 4x2, rst_i pulsed after 3 beats, then a full 8-beat frame of 0xFFFFFF -> checksum_o=0x07FFFFF8, frame_cnt_o=1.
REQ-038 Random valid_i gaps plus two back-to-back frames with enable_i held high -> results match the model; with CRC_EN, crc_o matches the model; without it, crc_o=0.
